wave_capture_arbiter: RTL and testbench

//  Shares the single write port of the 512x8 sample RAM between NCH voice channels.

---
 rtl/wave_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/wave_capture_arbiter.sv | 138 +++++++++++++
 tb/tb_wave_capture_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared constants, FSM encoding and sample conversion for the capture arbiter
package wave_pkg;

  localparam int NCH = 3;
  localparam int IDX_W = 6;
  localparam int ADDR_W = 1 + 2 + IDX_W;
  localparam logic [7:0] OFFSET = 8'h80;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_DONE = 1'b1;

  typedef enum logic {
    S_FILL = ST_FILL,
    S_DONE = ST_DONE
  } state_t;

  // Top byte of a signed 16-bit sample, moved to offset-binary for the RAM.
  function automatic logic [7:0] to_offset(input logic [15:0] s);
    return s[15:8] ^ OFFSET;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with a rotating priority pointer
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [N-1:0]  rot;
  logic [N-1:0]  pick;

  // Rotate requests so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot         = N'({req, req} >> ptr);
    pick        = rot & (~rot + 1'b1);
    grant       = N'(({pick, pick} << ptr) >> N);
    grant_valid = |req;
  end

  // Binary index of the granted requester, used to move the pointer past it.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  // Pointer starts at requester 0 and moves to the one after each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/wave_capture_arbiter.sv
// rtl/wave_capture_arbiter.sv - multi-channel sample capture sharing one RAM write port
module wave_capture_arbiter #(
  parameter int NCH   = wave_pkg::NCH,
  parameter int IDX_W = wave_pkg::IDX_W,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample,
  input  logic [16*NCH-1:0]   sample_in,
  input  logic [NCH-1:0]      channel_enable,
  input  logic                vsync,
  output logic                write_enable,
  output logic [2+IDX_W:0]    write_address,
  output logic [WIDTH-1:0]    write_sample,
  output logic                read_index,
  output logic [NCH-1:0]      overflow
);

  import wave_pkg::*;

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic               flip;
  logic               fill_done;
  logic [NCH-1:0]     pend;
  logic [NCH-1:0]     full;
  logic [NCH-1:0]     grant;
  logic               grant_valid;
  logic [NCH-1:0]     last_write;
  logic [NCH-1:0]     capture;
  logic [1:0]         gchan;
  logic [IDX_W-1:0]   gidx;
  logic [WIDTH-1:0]   gdata;
  logic [IDX_W-1:0]   idx       [NCH];
  logic [WIDTH-1:0]   pend_data [NCH];

  rr_arbiter #(.N(NCH)) u_arb (
    .clk         (clk),
    .rst_n       (reset),
    .req         (pend),
    .advance     (grant_valid),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Per-channel capture decision and the granted channel's address/data.
  // A channel whose final slot is being written this cycle counts as full,
  // so a sample arriving alongside that write can never wrap the index.
  always_comb begin
    last_write = '0;
    capture    = '0;
    gchan      = '0;
    gidx       = '0;
    gdata      = '0;
    for (int c = 0; c < NCH; c++) begin
      last_write[c] = grant[c] && (idx[c] == IDX_LAST);
      capture[c]    = new_sample && (state == S_FILL) && channel_enable[c]
                      && !full[c] && !last_write[c];
      if (grant[c]) begin
        gchan = 2'(c);
        gidx  = idx[c];
        gdata = pend_data[c];
      end
    end
    fill_done = (channel_enable != '0) && (&(full | ~channel_enable)) && (pend == '0);
  end

  // Fill/done sequencing; the bank flips on the first idle display cycle after a fill.
  always_comb begin
    state_nxt = state;
    flip      = 1'b0;
    case (state)
      S_FILL: if (fill_done) state_nxt = S_DONE;
      S_DONE: begin
        if (!vsync) begin
          state_nxt = S_FILL;
          flip      = 1'b1;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending samples, overrun flags, per-channel write indices and full flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      full     <= '0;
      overflow <= '0;
      for (int c = 0; c < NCH; c++) begin
        idx[c]       <= '0;
        pend_data[c] <= '0;
      end
    end else begin
      pend     <= capture | (pend & ~grant);
      overflow <= overflow | (capture & pend & ~grant);
      full     <= flip ? '0 : (full | last_write);
      for (int c = 0; c < NCH; c++) begin
        if (capture[c]) pend_data[c] <= WIDTH'(to_offset(sample_in[16*c +: 16]));
        if (flip) begin
          idx[c] <= '0;
        end else if (grant[c]) begin
          idx[c] <= idx[c] + 1'b1;
        end
      end
    end
  end

  // Registered RAM write port and display bank select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      read_index    <= 1'b0;
    end else begin
      write_enable <= grant_valid;
      if (grant_valid) begin
        write_address <= {~read_index, gchan, gidx};
        write_sample  <= gdata;
      end
      if (flip) read_index <= ~read_index;
    end
  end

endmodule

// File: tb/tb_wave_capture_arbiter.sv
// tb/tb_wave_capture_arbiter.sv - randomized and directed bench for wave_capture_arbiter
module tb_wave_capture_arbiter;

  localparam int NCH = 3;
  localparam int IDX_W = 6;
  localparam int WIDTH = 8;
  localparam int AW = 1 + 2 + IDX_W;
  localparam int SW = 16 * NCH;
  localparam int SAMPLES = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             new_sample = 1'b0;
  logic [SW-1:0]    sample_in = '0;
  logic [NCH-1:0]   channel_enable = '0;
  logic             vsync = 1'b1;
  logic             write_enable;
  logic [AW-1:0]    write_address;
  logic [WIDTH-1:0] write_sample;
  logic             read_index;
  logic [NCH-1:0]   overflow;

  wave_capture_arbiter #(.NCH(NCH), .IDX_W(IDX_W), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .new_sample     (new_sample),
    .sample_in      (sample_in),
    .channel_enable (channel_enable),
    .vsync          (vsync),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_sample   (write_sample),
    .read_index     (read_index),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_bad = 0;
  int exp_ch = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: samples written per channel, pending sample per channel, bank and done flag.
  int             m_cnt  [NCH];
  bit             m_pend [NCH];
  logic [7:0]     m_data [NCH];
  bit             m_done;
  bit             m_bank;
  logic [NCH-1:0] m_ovf;
  int             m_ptr;
  int             mg;
  bit             m_ok;
  bit             e_we;
  logic [AW-1:0]  e_addr;
  logic [7:0]     e_data;

  // Reference model stepped once per clock.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0;
        m_pend[c] = 0;
        m_data[c] = '0;
      end
      m_done = 0; m_bank = 0; m_ovf = '0; m_ptr = 0;
      e_we = 0; e_addr = '0; e_data = '0;
    end else begin
      m_ok = (channel_enable != '0);
      for (int c = 0; c < NCH; c++)
        if ((channel_enable[c] && m_cnt[c] < SAMPLES) || m_pend[c]) m_ok = 0;
      mg = -1;
      for (int k = 0; k < NCH; k++)
        if (mg < 0 && m_pend[(m_ptr + k) % NCH]) mg = (m_ptr + k) % NCH;
      e_we = (mg >= 0);
      if (mg >= 0) begin
        e_addr = {~m_bank, 2'(mg), IDX_W'(m_cnt[mg])};
        e_data = m_data[mg];
        m_pend[mg] = 0;
        m_cnt[mg]++;
        m_ptr = (mg + 1) % NCH;
      end
      for (int c = 0; c < NCH; c++) begin
        if (new_sample && !m_done && channel_enable[c] && m_cnt[c] < SAMPLES) begin
          if (m_pend[c]) m_ovf[c] = 1'b1;
          m_pend[c] = 1;
          m_data[c] = sample_in[16*c+8 +: 8] + 8'd128;
        end
      end
      if (!m_done && m_ok) begin
        m_done = 1;
      end else if (m_done && !vsync) begin
        m_done = 0;
        m_bank = ~m_bank;
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      end
    end
  end

  // Compare DUT outputs with the reference on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      check("write_enable", 64'(write_enable), 64'(e_we));
      if (e_we) begin
        check("write_address", 64'(write_address), 64'(e_addr));
        check("write_sample", 64'(write_sample), 64'(e_data));
      end
      check("read_index", 64'(read_index), 64'(m_bank));
      check("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (write_enable) begin
      wr_count++;
      if (exp_ch >= 0 && int'(write_address[IDX_W+1:IDX_W]) != exp_ch) wr_bad++;
    end
  endtask

  task automatic strobe(input logic [SW-1:0] data);
    sample_in = data;
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    channel_enable = '1;
    tick();
    tick();
    reset = 1'b1;

    // reset in the middle of a fill
    for (int i = 0; i < 17; i++) begin
      strobe(SW'({$urandom, $urandom}));
      repeat (3) tick();
    end
    strobe(SW'({$urandom, $urandom}));
    reset = 1'b0;
    #1;
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_addr", 64'(write_address), 64'd0);
    check("rst_sample", 64'(write_sample), 64'd0);
    check("rst_read_index", 64'(read_index), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    tick();
    check("rst_we_next", 64'(write_enable), 64'd0);
    reset = 1'b1;

    // first writes after reset, one channel per cycle
    strobe({16'h0000, 16'h8000, 16'h7F00});
    tick();
    check("t2_we0", 64'(write_enable), 64'd1);
    check("t2_addr0", 64'(write_address), 64'h100);
    check("t2_data0", 64'(write_sample), 64'hFF);
    check("t2_model_addr0", 64'(e_addr), 64'h100);
    tick();
    check("t2_addr1", 64'(write_address), 64'h140);
    check("t2_data1", 64'(write_sample), 64'h00);
    check("t2_model_data1", 64'(e_data), 64'h00);
    tick();
    check("t2_addr2", 64'(write_address), 64'h180);
    check("t2_data2", 64'(write_sample), 64'h80);

    // back-to-back strobes
    strobe(SW'({$urandom, $urandom}));
    strobe(SW'({$urandom, $urandom}));
    check("t3_ovf2", 64'(overflow[2]), 64'd1);
    check("t3_ovf0", 64'(overflow[0]), 64'd0);
    check("t3_model_ovf", 64'(m_ovf), 64'h6);
    repeat (6) tick();

    // full fill of all channels, then strobes while done, then the flip
    do_reset();
    wr_count = 0;
    for (int i = 0; i < SAMPLES; i++) begin
      strobe(SW'({$urandom, $urandom}));
      repeat (7) tick();
    end
    repeat (10) tick();
    check("t4_writes", 64'(wr_count), 64'd192);
    check("t4_read_index_done", 64'(read_index), 64'd0);
    wr_count = 0;
    for (int i = 0; i < 3; i++) begin
      strobe(SW'({$urandom, $urandom}));
      tick();
    end
    repeat (6) tick();
    check("t6_writes_in_done", 64'(wr_count), 64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_read_index", 64'(read_index), 64'd0);
    vsync = 1'b0;
    tick();
    check("t4_flip", 64'(read_index), 64'd1);
    vsync = 1'b1;
    strobe({16'h5600, 16'h3400, 16'h1234});
    tick();
    check("t4_bank0_we", 64'(write_enable), 64'd1);
    check("t4_bank0_addr", 64'(write_address), 64'h000);
    check("t4_bank0_data", 64'(write_sample), 64'h92);

    // single enabled channel, then no channels enabled
    do_reset();
    channel_enable = 3'b010;
    wr_count = 0;
    wr_bad = 0;
    exp_ch = 1;
    for (int i = 0; i < SAMPLES; i++) begin
      strobe(SW'({$urandom, $urandom}));
      repeat (3) tick();
    end
    repeat (8) tick();
    check("t5_writes", 64'(wr_count), 64'd64);
    check("t5_wrong_channel", 64'(wr_bad), 64'd0);
    check("t5_read_index", 64'(read_index), 64'd0);
    vsync = 1'b0;
    tick();
    check("t5_flip", 64'(read_index), 64'd1);
    vsync = 1'b1;
    exp_ch = -1;
    channel_enable = '0;
    vsync = 1'b0;
    wr_count = 0;
    for (int i = 0; i < 10; i++) begin
      strobe(SW'({$urandom, $urandom}));
      tick();
    end
    check("t5_no_flip", 64'(read_index), 64'd1);
    check("t5_no_writes", 64'(wr_count), 64'd0);
    vsync = 1'b1;

    // randomized traffic
    do_reset();
    channel_enable = '1;
    for (int i = 0; i < 3000; i++) begin
      new_sample = ($urandom % 4 == 0);
      sample_in = SW'({$urandom, $urandom});
      vsync = ($urandom % 10 != 0);
      if ($urandom % 300 == 0)
        channel_enable = ($urandom % 3 == 0) ? NCH'($urandom) : '1;
      tick();
    end
    new_sample = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
